// File: rtl/snowv_ks_xor_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : snowv_ks_xor_stream_if
// Brief    : Keystream, input-data and output-data handshake bundle for the
//            SNOW-V keystream XOR stage.
// Revision : 1.0 - initial release
// ============================================================================
interface snowv_ks_xor_stream_if #(
  parameter int DW  = 128,
  parameter int KSW = 256
);
  logic            ks_valid;
  logic [KSW-1:0]  ks_z;
  logic            ks_ready;
  logic            din_valid;
  logic [DW-1:0]   din;
  logic            din_ready;
  logic            dout_valid;
  logic [DW-1:0]   dout;
  logic [DW/8-1:0] dout_keep;
  logic            dout_last;
  logic            dout_ready;

  // Upstream/downstream environment side
  modport master (
    output ks_valid, ks_z, din_valid, din, dout_ready,
    input  ks_ready, din_ready, dout_valid, dout, dout_keep, dout_last
  );

  // XOR stage side
  modport slave (
    input  ks_valid, ks_z, din_valid, din, dout_ready,
    output ks_ready, din_ready, dout_valid, dout, dout_keep, dout_last
  );
endinterface
`default_nettype wire

// File: rtl/snowv_ks_xor_stream.sv
`default_nettype none
// ============================================================================
// Module   : snowv_ks_xor_stream
// Brief    : Buffers SNOW-V keystream words in a FIFO, slices them into DW-bit
//            chunks and XORs them onto a byte-length-bounded data stream.
// Revision : 1.0 - initial release
// ============================================================================
module snowv_ks_xor_stream #(
  parameter int DW       = 128,
  parameter int KSW      = 256,
  parameter int KS_DEPTH = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic [63:0] length,
  snowv_ks_xor_stream_if.slave bus,
  output logic             busy,
  output logic             done
);

  localparam int NCH = KSW / DW;
  localparam int BPB = DW / 8;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = $clog2(KS_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t          r_state, w_state_next;
  logic            r_alive;
  logic [KSW-1:0]  r_mem [KS_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count, w_count_next;
  logic [63:0]     r_rem;
  logic [IW-1:0]   r_idx;
  logic            r_dout_valid, r_dout_last, r_zero_done;
  logic [DW-1:0]   r_dout;
  logic [BPB-1:0]  r_keep;

  logic            w_empty, w_full, w_push, w_pop;
  logic            w_out_hs, w_can_beat, w_beat, w_is_last, w_wrap, w_start_msg;
  logic [KSW-1:0]  w_head;
  logic [DW-1:0]   w_chunks [NCH];
  logic [DW-1:0]   w_xor, w_data;
  logic [BPB-1:0]  w_keep;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == (AW+1)'(KS_DEPTH));
  assign w_push      = bus.ks_valid & bus.ks_ready;
  assign w_out_hs    = r_dout_valid & bus.dout_ready;
  // A beat needs data, a keystream word, an undelivered byte and a free slot
  assign w_can_beat  = (r_state == RUN) & ~w_empty & (r_rem != '0) &
                       (~r_dout_valid | bus.dout_ready);
  assign w_beat      = w_can_beat & bus.din_valid;
  assign w_is_last   = (r_rem <= 64'(BPB));
  assign w_wrap      = (r_idx == IW'(NCH - 1));
  assign w_pop       = (w_beat & (w_wrap | w_is_last)) |
                       ((r_state == FLUSH) & ~w_empty);
  assign w_start_msg = (r_state == IDLE) & start & (length != '0);

  assign w_head = r_mem[r_rptr];
  for (genvar g = 0; g < NCH; g++) begin : g_chunk
    assign w_chunks[g] = w_head[g*DW +: DW];
  end
  assign w_xor = bus.din ^ w_chunks[r_idx];

  // r_alive keeps ks_ready low until the first clock after reset release
  assign bus.ks_ready   = r_alive & (r_state != FLUSH) & ~w_full;
  assign bus.din_ready  = w_can_beat;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout       = r_dout;
  assign bus.dout_keep  = r_keep;
  assign bus.dout_last  = r_dout_last;
  assign busy           = (r_state != IDLE);
  assign done           = (w_out_hs & r_dout_last) | r_zero_done;

  // Byte-enable: bytes at or beyond the remaining count are dropped and zeroed
  always_comb begin
    w_keep = '0;
    w_data = '0;
    for (int b = 0; b < BPB; b++) begin
      if (64'(b) < r_rem) begin
        w_keep[b]        = 1'b1;
        w_data[8*b +: 8] = w_xor[8*b +: 8];
      end
    end
  end

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_alive <= 1'b1;
    end
  end

  // Next state: skip FLUSH when nothing is left in the FIFO at the final handshake
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_msg) w_state_next = RUN;
      RUN:     if (w_out_hs && r_dout_last)
                 w_state_next = (w_count_next == '0) ? IDLE : FLUSH;
      FLUSH:   if (w_empty && !r_dout_valid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Keystream FIFO storage; contents need no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.ks_z;
  end

  // Keystream FIFO pointers and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Message bookkeeping and the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem        <= '0;
      r_idx        <= '0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_keep       <= '0;
      r_dout_last  <= 1'b0;
      r_zero_done  <= 1'b0;
    end else begin
      r_zero_done <= (r_state == IDLE) & start & (length == '0);
      if (w_start_msg) begin
        r_rem <= length;
        r_idx <= '0;
      end else if (w_beat) begin
        r_rem <= w_is_last ? '0 : r_rem - 64'(BPB);
        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      end
      if (w_beat) begin
        r_dout_valid <= 1'b1;
        r_dout       <= w_data;
        r_keep       <= w_keep;
        r_dout_last  <= w_is_last;
      end else if (w_out_hs) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
